spi_apb_slave: RTL and testbench

SPI_APB_SLAVE -- requirements
Module: spi_apb_slave

---
 rtl/spi_apb_slave.sv | 212 +++++++++++++++++++++
 tb/tb_spi_apb_slave.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_apb_slave.sv
// APB register slave for a byte-wide SPI core: control, status, clock divider,
// TX/RX byte FIFOs and a level interrupt.
module spi_apb_slave #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [3:0]            pstrb,
    input  logic [2:0]            pprot,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  spi_en,
    output logic [15:0]           clkdiv,
    output logic                  irq
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

    localparam logic [4:0] A_CTRL   = 5'h00;
    localparam logic [4:0] A_STATUS = 5'h04;
    localparam logic [4:0] A_TXDATA = 5'h08;
    localparam logic [4:0] A_RXDATA = 5'h0C;
    localparam logic [4:0] A_CLKDIV = 5'h10;

    localparam logic [DATA_WIDTH-1:0] STATUS_W1C = DATA_WIDTH'(32'h10);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

    apb_state_t state, state_next;
    logic       waited;

    logic [2:0] ctrl;
    logic       rx_ovf;

    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [7:0]  rx_mem [FIFO_DEPTH];
    logic [PW:0] tx_wptr, tx_rptr;
    logic [PW:0] rx_wptr, rx_rptr;
    logic        tx_empty, tx_full, rx_empty, rx_full;
    logic [7:0]  rx_head;

    logic [4:0]            addr;
    logic                  rx_rd_sel;
    logic                  commit;
    logic                  err;
    logic                  wr_ok, rd_ok;
    logic                  tx_push, tx_pop, rx_push, rx_pop;
    logic                  ovf_set, ovf_clr;
    logic [DATA_WIDTH-1:0] rd_word;

    logic unused_inputs;
    assign unused_inputs = ^{paddr[ADDR_WIDTH-1:5], pstrb[3:2], pprot[2:1]};

    // ---------------- FIFO status ----------------
    assign tx_empty = (tx_wptr == tx_rptr);
    assign tx_full  = (tx_wptr[PW] != tx_rptr[PW]) && (tx_wptr[PW-1:0] == tx_rptr[PW-1:0]);
    assign rx_empty = (rx_wptr == rx_rptr);
    assign rx_full  = (rx_wptr[PW] != rx_rptr[PW]) && (rx_wptr[PW-1:0] == rx_rptr[PW-1:0]);

    assign tx_data  = tx_mem[tx_rptr[PW-1:0]];
    assign tx_valid = !tx_empty;
    assign rx_head  = rx_mem[rx_rptr[PW-1:0]];

    assign spi_en = ctrl[0];

    // ---------------- APB protocol FSM ----------------
    assign addr      = paddr[4:0];
    assign rx_rd_sel = !pwrite && (addr == A_RXDATA);
    // RXDATA reads hold off one ACCESS cycle; waited marks the second one
    assign pready    = (state == ACCESS) && psel && (!rx_rd_sel || waited);
    assign commit    = pready;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state  <= IDLE;
            waited <= 1'b0;
        end else begin
            state  <= state_next;
            waited <= (state == ACCESS) && !pready;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (psel && !penable) state_next = SETUP;
            end
            SETUP: begin
                if (!psel)        state_next = IDLE;
                else if (penable) state_next = ACCESS;
            end
            ACCESS: begin
                if (!psel)       state_next = IDLE;
                else if (pready) state_next = (psel && !penable) ? SETUP : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- Access decode ----------------
    always_comb begin
        err = 1'b0;
        if ((addr[1:0] != 2'b00) || (addr > A_CLKDIV)) begin
            err = 1'b1;
        end else begin
            case (addr)
                A_CTRL, A_CLKDIV: err = pwrite && !pprot[0];
                A_STATUS:         err = pwrite && ((pwdata & ~STATUS_W1C) != '0);
                A_TXDATA:         err = !pwrite || tx_full;
                A_RXDATA:         err = pwrite || rx_empty;
                default:          err = 1'b1;
            endcase
        end
    end

    assign wr_ok = commit && pwrite && !err;
    assign rd_ok = commit && !pwrite && !err;

    assign tx_push = wr_ok && (addr == A_TXDATA) && pstrb[0];
    assign tx_pop  = tx_valid && tx_ready && spi_en;
    assign rx_pop  = rd_ok && (addr == A_RXDATA);
    // a pop completing in the same cycle frees the slot for an incoming byte
    assign rx_push = rx_valid && (!rx_full || rx_pop);
    assign ovf_set = rx_valid && rx_full && !rx_pop;
    assign ovf_clr = wr_ok && (addr == A_STATUS) && pwdata[4];

    always_comb begin
        rd_word = '0;
        case (addr)
            A_CTRL:   rd_word[2:0]  = ctrl;
            A_STATUS: rd_word[4:0]  = {rx_ovf, rx_full, rx_empty, tx_full, tx_empty};
            A_RXDATA: rd_word[7:0]  = rx_head;
            A_CLKDIV: rd_word[15:0] = clkdiv;
            default:  rd_word       = '0;
        endcase
    end

    assign prdata  = rd_ok ? rd_word : '0;
    assign pslverr = commit && err;

    // ---------------- Registers ----------------
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            ctrl   <= '0;
            clkdiv <= 16'h0004;
        end else begin
            if (wr_ok && (addr == A_CTRL) && pstrb[0]) ctrl <= pwdata[2:0];
            if (wr_ok && (addr == A_CLKDIV)) begin
                if (pstrb[0]) clkdiv[7:0]  <= pwdata[7:0];
                if (pstrb[1]) clkdiv[15:8] <= pwdata[15:8];
            end
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            rx_ovf <= 1'b0;
        end else if (ovf_set) begin
            rx_ovf <= 1'b1;
        end else if (ovf_clr) begin
            rx_ovf <= 1'b0;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= (ctrl[1] && tx_empty) || (ctrl[2] && !rx_empty) || rx_ovf;
        end
    end

    // ---------------- FIFOs ----------------
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            rx_wptr <= '0;
            rx_rptr <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + PTR_ONE;
            if (tx_pop)  tx_rptr <= tx_rptr + PTR_ONE;
            if (rx_push) rx_wptr <= rx_wptr + PTR_ONE;
            if (rx_pop)  rx_rptr <= rx_rptr + PTR_ONE;
        end
    end

    always_ff @(posedge pclk) begin
        if (tx_push) tx_mem[tx_wptr[PW-1:0]] <= pwdata[7:0];
        if (rx_push) rx_mem[rx_wptr[PW-1:0]] <= rx_data;
    end

endmodule

// File: tb/tb_spi_apb_slave.sv
// Randomized self-checking bench for spi_apb_slave against a queue-based model
// of the register map, FIFOs and interrupt.
module tb_spi_apb_slave;

    localparam int unsigned DEPTH = 4;

    logic        pclk = 1'b0;
    logic        preset_n;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        spi_en;
    logic [15:0] clkdiv;
    logic        irq;

    spi_apb_slave #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .pclk(pclk),
        .preset_n(preset_n),
        .psel(psel),
        .penable(penable),
        .pwrite(pwrite),
        .paddr(paddr),
        .pwdata(pwdata),
        .pstrb(pstrb),
        .pprot(pprot),
        .prdata(prdata),
        .pready(pready),
        .pslverr(pslverr),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .spi_en(spi_en),
        .clkdiv(clkdiv),
        .irq(irq)
    );

    always #5 pclk = ~pclk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // reference model state
    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    logic [2:0]  m_ctrl;
    logic [15:0] m_clkdiv;
    logic        m_ovf;
    logic        prev_cond;

    logic [31:0] rd;
    logic        er;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic irq_cond();
        return (m_ctrl[1] && txq.size() == 0) || (m_ctrl[2] && rxq.size() != 0) || m_ovf;
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s    = '0;
        s[0] = (txq.size() == 0);
        s[1] = (txq.size() == DEPTH);
        s[2] = (rxq.size() == 0);
        s[3] = (rxq.size() == DEPTH);
        s[4] = m_ovf;
        return s;
    endfunction

    task automatic model_reset();
        txq.delete();
        rxq.delete();
        m_ctrl    = '0;
        m_clkdiv  = 16'h0004;
        m_ovf     = 1'b0;
        prev_cond = 1'b0;
    endtask

    task automatic do_reset();
        preset_n = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        model_reset();
        @(negedge pclk);
        check("rst_prdata",   prdata,            32'h0);
        check("rst_pready",   32'(pready),       32'h0);
        check("rst_pslverr",  32'(pslverr),      32'h0);
        check("rst_tx_valid", 32'(tx_valid),     32'h0);
        check("rst_irq",      32'(irq),          32'h0);
        check("rst_spi_en",   32'(spi_en),       32'h0);
        check("rst_clkdiv",   32'(clkdiv),       32'h4);
        @(posedge pclk);
        #1 preset_n = 1'b1;
    endtask

    // One SPI-side cycle; called and returns at posedge+1.
    task automatic spi_cycle(input logic rxv, input logic [7:0] rxd, input logic txr);
        rx_valid = rxv;
        rx_data  = rxd;
        tx_ready = txr;
        @(negedge pclk);
        check("tx_valid", 32'(tx_valid), 32'(txq.size() != 0));
        if (txq.size() != 0) check("tx_data", 32'(tx_data), 32'(txq[0]));
        check("irq",    32'(irq),    32'(prev_cond));
        check("spi_en", 32'(spi_en), 32'(m_ctrl[0]));
        check("clkdiv", 32'(clkdiv), 32'(m_clkdiv));
        prev_cond = irq_cond();
        if (txr && m_ctrl[0] && txq.size() != 0) void'(txq.pop_front());
        if (rxv) begin
            if (rxq.size() < DEPTH) rxq.push_back(rxd);
            else m_ovf = 1'b1;
        end
        @(posedge pclk);
        #1;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
    endtask

    // Full APB transfer; side_* are applied during the completing cycle only.
    task automatic apb(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot,
                       input logic side_rxv, input logic [7:0] side_rxd, input logic side_txr,
                       output logic [31:0] rdata, output logic err);
        int unsigned waits;
        logic        done;
        int          a;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic        tx_pops;
        waits = 0;
        done  = 1'b0;
        @(posedge pclk);
        #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = wdata; pstrb = strb; pprot = prot;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        while (!done && waits < 8) begin
            @(negedge pclk);
            if (pready) done = 1'b1;
            else waits++;
        end
        rdata = prdata;
        err   = pslverr;
        if (!done) begin
            check("apb_timeout", 32'(pready), 32'h1);
            @(posedge pclk);
            #1;
            psel = 1'b0; penable = 1'b0;
            return;
        end

        a = int'(addr[4:0]);
        exp_err = (a % 4 != 0) || (a > 16) || (wr && a == 12) || (!wr && a == 8) ||
                  (wr && a == 4 && (wdata & ~32'h10) != 0) ||
                  (wr && a == 8 && txq.size() == DEPTH) ||
                  (!wr && a == 12 && rxq.size() == 0) ||
                  (wr && (a == 0 || a == 16) && !prot[0]);
        exp_rd = '0;
        if (!wr && !exp_err) begin
            case (a)
                0:       exp_rd = 32'(m_ctrl);
                4:       exp_rd = m_status();
                12:      exp_rd = 32'(rxq[0]);
                16:      exp_rd = 32'(m_clkdiv);
                default: exp_rd = '0;
            endcase
        end
        check($sformatf("waits@%0h", a), waits, 32'((!wr && a == 12) ? 2 : 1));
        check($sformatf("pslverr@%0h", a), 32'(err), 32'(exp_err));
        if (!wr) check($sformatf("prdata@%0h", a), rdata, exp_rd);

        rx_valid = side_rxv;
        rx_data  = side_rxd;
        tx_ready = side_txr;
        tx_pops  = side_txr && m_ctrl[0] && txq.size() != 0;
        if (tx_pops) check("tx_data_commit", 32'(tx_data), 32'(txq[0]));
        prev_cond = irq_cond();

        if (tx_pops) void'(txq.pop_front());
        if (!exp_err) begin
            if (wr) begin
                case (a)
                    0:  if (strb[0]) m_ctrl = wdata[2:0];
                    4:  if (wdata[4]) m_ovf = 1'b0;
                    8:  if (strb[0]) txq.push_back(wdata[7:0]);
                    16: begin
                        if (strb[0]) m_clkdiv[7:0]  = wdata[7:0];
                        if (strb[1]) m_clkdiv[15:8] = wdata[15:8];
                    end
                    default: ;
                endcase
            end else if (a == 12) begin
                void'(rxq.pop_front());
            end
        end
        if (side_rxv) begin
            if (rxq.size() < DEPTH) rxq.push_back(side_rxd);
            else m_ovf = 1'b1;
        end

        @(posedge pclk);
        #1;
        psel = 1'b0; penable = 1'b0;
        rx_valid = 1'b0; tx_ready = 1'b0;
    endtask

    task automatic wr_reg(input logic [31:0] addr, input logic [31:0] wdata);
        apb(addr, 1'b1, wdata, 4'hF, 3'b001, 1'b0, 8'h00, 1'b0, rd, er);
    endtask

    task automatic rd_reg(input logic [31:0] addr);
        apb(addr, 1'b0, 32'h0, 4'hF, 3'b001, 1'b0, 8'h00, 1'b0, rd, er);
    endtask

    initial begin
        do_reset();
        rd_reg(32'h00);
        rd_reg(32'h04);
        check("status_after_rst", rd, 32'h05);
        rd_reg(32'h10);

        // TX ordering, stall without enable, pop with enable
        wr_reg(32'h08, 32'hA5);
        wr_reg(32'h08, 32'h3C);
        spi_cycle(1'b0, 8'h00, 1'b1);
        check("tx_head_a5", 32'(tx_data), 32'hA5);
        wr_reg(32'h00, 32'h1);
        spi_cycle(1'b0, 8'h00, 1'b1);
        spi_cycle(1'b0, 8'h00, 1'b1);
        rd_reg(32'h04);
        check("tx_empty_after_pops", 32'(rd[0]), 32'h1);

        // TX overflow by writes
        do_reset();
        for (int k = 0; k < 5; k++) begin
            apb(32'h08, 1'b1, 32'h40 + 32'(k), 4'hF, 3'b001, 1'b0, 8'h00, 1'b0, rd, er);
            check($sformatf("tx_fill_err%0d", k), 32'(er), 32'(k == 4));
        end
        rd_reg(32'h04);
        check("tx_full_bits", rd & 32'h3, 32'h2);

        // RXDATA wait state and empty read
        do_reset();
        spi_cycle(1'b1, 8'h11, 1'b0);
        rd_reg(32'h0C);
        check("rx_read_data", rd, 32'h11);
        rd_reg(32'h0C);
        check("rx_empty_read_err", 32'(er), 32'h1);

        // RX overflow and W1C clear with irq lag
        do_reset();
        for (int k = 0; k < 5; k++) spi_cycle(1'b1, 8'(8'h20 + k), 1'b0);
        spi_cycle(1'b0, 8'h00, 1'b0);
        spi_cycle(1'b0, 8'h00, 1'b0);
        check("irq_ovf", 32'(irq), 32'h1);
        wr_reg(32'h04, 32'h10);
        spi_cycle(1'b0, 8'h00, 1'b0);
        spi_cycle(1'b0, 8'h00, 1'b0);
        check("irq_cleared", 32'(irq), 32'h0);

        // CLKDIV strobes, privilege and out-of-range address
        do_reset();
        apb(32'h10, 1'b1, 32'hFFFF, 4'b0001, 3'b001, 1'b0, 8'h00, 1'b0, rd, er);
        check("clkdiv_strb", 32'(clkdiv), 32'h00FF);
        apb(32'h10, 1'b1, 32'hFFFF, 4'b0011, 3'b000, 1'b0, 8'h00, 1'b0, rd, er);
        check("clkdiv_unpriv", 32'(clkdiv), 32'h00FF);
        rd_reg(32'h14);

        // same-cycle RX push with pop on full, and set-vs-clear of rx_ovf
        do_reset();
        for (int k = 0; k < 4; k++) spi_cycle(1'b1, 8'(8'h30 + k), 1'b0);
        apb(32'h0C, 1'b0, 32'h0, 4'hF, 3'b001, 1'b1, 8'h77, 1'b0, rd, er);
        rd_reg(32'h04);
        check("rx_push_on_pop", rd & 32'h18, 32'h08);
        apb(32'h04, 1'b1, 32'h10, 4'hF, 3'b001, 1'b1, 8'h78, 1'b0, rd, er);
        rd_reg(32'h04);
        check("ovf_set_wins", 32'(rd[4]), 32'h1);
        for (int k = 0; k < 4; k++) rd_reg(32'h0C);

        // simultaneous TX push/pop, and disable does not flush
        do_reset();
        wr_reg(32'h00, 32'h1);
        wr_reg(32'h08, 32'h01);
        apb(32'h08, 1'b1, 32'h02, 4'hF, 3'b001, 1'b0, 8'h00, 1'b1, rd, er);
        wr_reg(32'h00, 32'h0);
        spi_cycle(1'b0, 8'h00, 1'b1);
        check("tx_kept_disabled", 32'(tx_data), 32'h02);
        apb(32'h08, 1'b1, 32'h99, 4'b1110, 3'b001, 1'b0, 8'h00, 1'b0, rd, er);
        rd_reg(32'h04);

        // reset during the RXDATA wait state
        do_reset();
        spi_cycle(1'b1, 8'h5A, 1'b0);
        @(posedge pclk);
        #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0C;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        @(negedge pclk);
        check("r028_setup_pready", 32'(pready), 32'h0);
        @(negedge pclk);
        check("r028_wait_pready", 32'(pready), 32'h0);
        preset_n = 1'b0;
        #1;
        check("r028_rst_pready", 32'(pready), 32'h0);
        psel = 1'b0; penable = 1'b0;
        model_reset();
        @(posedge pclk);
        #1 preset_n = 1'b1;
        rd_reg(32'h04);
        check("r028_rx_empty", rd, 32'h05);

        // randomized mix of APB accesses and SPI-side traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r, addr, wdata;
            logic        wr;
            logic [3:0]  strb;
            logic [2:0]  prot;
            int          a5;
            if ($urandom_range(0, 9) < 6) begin
                case ($urandom_range(0, 7))
                    0: a5 = 0;
                    1: a5 = 4;
                    2: a5 = 8;
                    3: a5 = 12;
                    4: a5 = 16;
                    5: a5 = 20 + 4 * int'($urandom_range(0, 2));
                    6: a5 = 4 * int'($urandom_range(0, 7)) + int'($urandom_range(1, 3));
                    default: a5 = 12;
                endcase
                r     = $urandom();
                addr  = {r[31:5], 5'(a5)};
                wr    = 1'($urandom_range(0, 1));
                wdata = $urandom();
                if (a5 == 4 && $urandom_range(0, 1) == 1) wdata = 32'h10;
                strb  = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15));
                prot  = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 3) != 0) prot[0] = 1'b1;
                apb(addr, wr, wdata, strb, prot, 1'b0, 8'h00, 1'b0, rd, er);
            end else begin
                r = $urandom();
                spi_cycle(1'($urandom_range(0, 9) < 3), r[7:0], 1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
